// File: rtl/pending_index_encoder.sv
`default_nettype none
// ============================================================================
// Module   : pending_index_encoder
// Brief    : Sticky 32-source pending register with a round-robin or
//            fixed-priority 5-bit index offered over a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module pending_index_encoder #(
    parameter int N         = 32,
    parameter int W         = 5,
    parameter int PRIO_MODE = 0
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         clr_en,
    input  logic [W-1:0] clr_idx,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic [W:0]   pend_count,
    output logic         dup_req
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_OFFER = 1'b1;

    logic [0:0]     r_state;
    logic [0:0]     w_state_nxt;
    logic [N-1:0]   r_pending;
    logic [W-1:0]   r_out_idx;
    logic [W-1:0]   r_rr_ptr;
    logic           r_dup_req;

    logic [N-1:0]   w_clr_mask;
    logic [N-1:0]   w_ack_mask;
    logic [N-1:0]   w_eligible;
    logic [W-1:0]   w_ptr;
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_scan;
    logic [W-1:0]   w_sel_off;
    logic [W-1:0]   w_sel_idx;
    logic           w_load;
    logic           w_accept;
    logic [W:0]     w_count;

    always_comb begin
        w_clr_mask = '0;
        w_ack_mask = '0;
        if (clr_en) w_clr_mask[clr_idx] = 1'b1;
        if (r_state == c_ST_OFFER && out_ready) w_ack_mask[r_out_idx] = 1'b1;
    end

    assign w_eligible = r_pending & ~w_clr_mask;

    // Rotating by the pointer turns round-robin into a lowest-bit search;
    // fixed priority is the same search with a zero pointer.
    assign w_ptr  = (PRIO_MODE == 0) ? r_rr_ptr : '0;
    assign w_dbl  = {w_eligible, w_eligible} >> w_ptr;
    assign w_scan = w_dbl[N-1:0];

    always_comb begin
        w_sel_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_scan[i]) w_sel_off = W'(i);
        end
    end

    assign w_sel_idx = w_sel_off + w_ptr;

    always_comb begin
        w_count = '0;
        for (int i = 0; i < N; i++) begin
            w_count = w_count + (W+1)'(r_pending[i]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (|w_eligible) begin
                    w_state_nxt = c_ST_OFFER;
                    w_load      = 1'b1;
                end
            end
            c_ST_OFFER: begin
                if (out_ready) begin
                    w_state_nxt = c_ST_IDLE;
                    w_accept    = 1'b1;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_ST_IDLE;
            r_pending <= '0;
            r_out_idx <= '0;
            r_rr_ptr  <= '0;
            r_dup_req <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            // Set wins over clear and acknowledge on the same bit.
            r_pending <= (r_pending & ~w_clr_mask & ~w_ack_mask) | req;
            r_dup_req <= |(req & r_pending & ~w_clr_mask & ~w_ack_mask);
            if (w_load) r_out_idx <= w_sel_idx;
            if (w_accept && PRIO_MODE == 0) r_rr_ptr <= r_out_idx + W'(1);
        end
    end

    assign out_valid  = (r_state == c_ST_OFFER);
    assign out_idx    = r_out_idx;
    assign pending    = r_pending;
    assign pend_count = w_count;
    assign dup_req    = r_dup_req;

endmodule
`default_nettype wire

// File: tb/tb_pending_index_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pending_index_encoder
// Brief    : Directed self-checking bench for round-robin and fixed-priority
//            instances of pending_index_encoder.
// Revision : 1.0
// ============================================================================
module tb_pending_index_encoder;

    localparam int N = 32;
    localparam int W = 5;

    logic         clock;
    logic         reset_n;
    logic [N-1:0] req;
    logic         clr_en;
    logic [W-1:0] clr_idx;
    logic         out_ready;

    logic         rr_valid, fx_valid;
    logic [W-1:0] rr_idx, fx_idx;
    logic [N-1:0] rr_pend, fx_pend;
    logic [W:0]   rr_cnt, fx_cnt;
    logic         rr_dup, fx_dup;

    int n_checks;
    int n_errors;

    pending_index_encoder #(.N(N), .W(W), .PRIO_MODE(0)) u_rr (
        .clock(clock), .reset_n(reset_n), .req(req), .clr_en(clr_en),
        .clr_idx(clr_idx), .out_valid(rr_valid), .out_idx(rr_idx),
        .out_ready(out_ready), .pending(rr_pend), .pend_count(rr_cnt),
        .dup_req(rr_dup)
    );

    pending_index_encoder #(.N(N), .W(W), .PRIO_MODE(1)) u_fx (
        .clock(clock), .reset_n(reset_n), .req(req), .clr_en(clr_en),
        .clr_idx(clr_idx), .out_valid(fx_valid), .out_idx(fx_idx),
        .out_ready(out_ready), .pending(fx_pend), .pend_count(fx_cnt),
        .dup_req(fx_dup)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset_n   = 1'b0;
        req       = '0;
        clr_en    = 1'b0;
        clr_idx   = '0;
        out_ready = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        check_val("rst_pending", rr_pend, 0);
        check_val("rst_valid", rr_valid, 0);
        check_val("rst_idx", rr_idx, 0);
        check_val("rst_count", rr_cnt, 0);
        check_val("rst_dup", rr_dup, 0);

        // Single request on bit 8
        req = 32'h0000_0100; out_ready = 1'b1;
        tick(); req = '0;
        check_val("single_pend_c1", rr_pend, 32'h100);
        check_val("single_valid_c1", rr_valid, 0);
        tick();
        check_val("single_valid_c2", rr_valid, 1);
        check_val("single_idx_c2", rr_idx, 8);
        tick();
        check_val("single_pend_c3", rr_pend, 0);
        check_val("single_valid_c3", rr_valid, 0);

        // Pointer now 9: bits {3,9} must yield 9 then 3
        req = (32'h1 << 3) | (32'h1 << 9);
        tick(); req = '0;
        tick();
        check_val("rr9_first", rr_idx, 9);
        repeat (2) tick();
        check_val("rr9_second", rr_idx, 3);
        tick();
        check_val("rr9_drained", rr_pend, 0);

        // Move pointer to 31 through an accept on bit 30
        req = 32'h1 << 30;
        tick(); req = '0;
        tick();
        check_val("rr30_idx", rr_idx, 30);
        tick();

        // Wrap: bits {2,31} with pointer 31
        req = (32'h1 << 2) | (32'h1 << 31);
        tick(); req = '0;
        tick();
        check_val("wrap_first", rr_idx, 31);
        repeat (2) tick();
        check_val("wrap_second", rr_idx, 2);
        tick();

        // Pointer now 3: bits {1,3} must yield 3 first
        req = 32'h0000_000A;
        tick(); req = '0;
        tick();
        check_val("rr3_first", rr_idx, 3);
        repeat (6) tick();
        check_val("rr_idle_drained", rr_pend, 0);
        check_val("fx_idle_drained", fx_pend, 0);

        // Fixed priority: 0, 4, 31 at two-cycle spacing
        req = 32'h8000_0011;
        tick(); req = '0;
        check_val("fx_cnt_c1", fx_cnt, 3);
        tick();
        check_val("fx_idx0", fx_idx, 0);
        check_val("fx_valid0", fx_valid, 1);
        check_val("fx_cnt3", fx_cnt, 3);
        tick();
        check_val("fx_cnt2_idle", fx_cnt, 2);
        tick();
        check_val("fx_idx4", fx_idx, 4);
        check_val("fx_cnt2", fx_cnt, 2);
        repeat (2) tick();
        check_val("fx_idx31", fx_idx, 31);
        check_val("fx_cnt1", fx_cnt, 1);
        tick();
        check_val("fx_cnt0", fx_cnt, 0);
        repeat (4) tick();

        // Backpressure with a duplicate request during the hold
        out_ready = 1'b0;
        req = 32'h20;
        tick(); req = '0;
        tick();
        for (int k = 0; k < 10; k++) begin
            check_val($sformatf("bp_valid_%0d", k), rr_valid, 1);
            check_val($sformatf("bp_idx_%0d", k), rr_idx, 5);
            check_val($sformatf("bp_dup_%0d", k), rr_dup, (k == 5) ? 1 : 0);
            req = (k == 4) ? 32'h20 : '0;
            tick();
        end
        req = '0;
        out_ready = 1'b1;
        tick();
        check_val("bp_drained", rr_pend, 0);
        repeat (4) tick();

        // Simultaneous clear, request and acknowledge on bit 7
        out_ready = 1'b0;
        req = 32'h80;
        tick(); req = '0;
        tick();
        check_val("sim_idx", rr_idx, 7);
        clr_en = 1'b1; clr_idx = 5'd7; req = 32'h80; out_ready = 1'b1;
        tick();
        req = '0; out_ready = 1'b0;
        check_val("sim_set_wins", rr_pend[7], 1);
        check_val("sim_no_dup", rr_dup, 0);
        check_val("sim_masked_idle", rr_valid, 0);
        tick();
        clr_en = 1'b0;
        check_val("sim_cleared", rr_pend, 0);
        check_val("sim_still_idle", rr_valid, 0);
        repeat (2) tick();

        // Clear of the offered index does not retract the offer
        req = 32'h400;
        tick(); req = '0;
        tick();
        clr_en = 1'b1; clr_idx = 5'd10;
        tick();
        clr_en = 1'b0;
        check_val("noretract_pend", rr_pend, 0);
        check_val("noretract_valid", rr_valid, 1);
        check_val("noretract_idx", rr_idx, 10);
        out_ready = 1'b1;
        tick();
        check_val("noretract_done", rr_valid, 0);
        out_ready = 1'b0;

        // Full register and asynchronous reset mid-offer
        req = 32'hFFFF_FFFF;
        tick(); req = '0;
        tick();
        check_val("full_count", rr_cnt, 32);
        check_val("full_valid", rr_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        check_val("arst_valid", rr_valid, 0);
        check_val("arst_pending", rr_pend, 0);
        check_val("arst_count", rr_cnt, 0);
        check_val("arst_fx_valid", fx_valid, 0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
